// File: rtl/decode_if.sv
// Decode-stage bus: fetch-side inputs, register-file read port and registered decode outputs.
// The slave modport is the decode stage; the master side drives instructions and reads results.
interface decode_if;
  logic [31:0] pc_in;
  logic [31:0] next_pc_in;
  logic [31:0] instruction_in;
  logic        valid_in;
  logic        stall;
  logic        invalidate;

  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] rs1_data_out;
  logic [31:0] rs2_data_out;
  logic [31:0] imm_out;
  logic [4:0]  rd_address_out;
  logic [4:0]  rs1_address_out;
  logic [4:0]  rs2_address_out;
  logic [4:0]  alu_function_out;
  logic [1:0]  alu_select_a_out;
  logic        alu_select_b_out;
  logic [2:0]  funct3_out;
  logic        load_out;
  logic        store_out;
  logic        branch_out;
  logic        jump_out;
  logic        csr_out;
  logic        ecall_out;
  logic        ebreak_out;
  logic        mret_out;
  logic        illegal_out;
  logic        valid_out;

  modport slave (
    input  pc_in, next_pc_in, instruction_in, valid_in, stall, invalidate, rs1_data, rs2_data,
    output rs1_address, rs2_address,
    output pc_out, next_pc_out, rs1_data_out, rs2_data_out, imm_out,
    output rd_address_out, rs1_address_out, rs2_address_out,
    output alu_function_out, alu_select_a_out, alu_select_b_out, funct3_out,
    output load_out, store_out, branch_out, jump_out, csr_out,
    output ecall_out, ebreak_out, mret_out, illegal_out, valid_out
  );

  modport master (
    output pc_in, next_pc_in, instruction_in, valid_in, stall, invalidate, rs1_data, rs2_data,
    input  rs1_address, rs2_address,
    input  pc_out, next_pc_out, rs1_data_out, rs2_data_out, imm_out,
    input  rd_address_out, rs1_address_out, rs2_address_out,
    input  alu_function_out, alu_select_a_out, alu_select_b_out, funct3_out,
    input  load_out, store_out, branch_out, jump_out, csr_out,
    input  ecall_out, ebreak_out, mret_out, illegal_out, valid_out
  );
endinterface

// File: rtl/decode.sv
// RV32I decode stage with one registered cycle of latency, stall/invalidate control.
// Define DECODE_RV32M_EN to decode the M-extension (MUL..REMU) instead of trapping it as illegal.
module decode (
  input  logic    clk,
  input  logic    reset,
  decode_if.slave bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [4:0] AluAdd  = 5'd0;
  localparam logic [4:0] AluSub  = 5'd1;
  localparam logic [4:0] AluSll  = 5'd2;
  localparam logic [4:0] AluSlt  = 5'd3;
  localparam logic [4:0] AluSltu = 5'd4;
  localparam logic [4:0] AluXor  = 5'd5;
  localparam logic [4:0] AluSrl  = 5'd6;
  localparam logic [4:0] AluSra  = 5'd7;
  localparam logic [4:0] AluOr   = 5'd8;
  localparam logic [4:0] AluAnd  = 5'd9;

  localparam logic [1:0] SelRs1  = 2'd0;
  localparam logic [1:0] SelPc   = 2'd1;
  localparam logic [1:0] SelZero = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  alu;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic [2:0]  funct3;
    logic        load;
    logic        store;
    logic        branch;
    logic        jump;
    logic        csr;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        illegal;
  } ctrl_t;

  ctrl_t       dec;
  ctrl_t       ctrl_d, ctrl_q;
  logic        valid_d, valid_q;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr  = bus.instruction_in;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign bus.rs1_address = instr[19:15];
  assign bus.rs2_address = instr[24:20];

  // alt selects SUB/SRA over ADD/SRL; it has no effect on the other funct3 codes.
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [4:0] fn;
    case (f3)
      3'b000:  fn = alt ? AluSub : AluAdd;
      3'b001:  fn = AluSll;
      3'b010:  fn = AluSlt;
      3'b011:  fn = AluSltu;
      3'b100:  fn = AluXor;
      3'b101:  fn = alt ? AluSra : AluSrl;
      3'b110:  fn = AluOr;
      default: fn = AluAnd;
    endcase
    return fn;
  endfunction

  always_comb begin
    dec          = '0;
    dec.pc       = bus.pc_in;
    dec.next_pc  = bus.next_pc_in;
    dec.rs1_data = bus.rs1_data;
    dec.rs2_data = bus.rs2_data;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.funct3   = funct3;
    dec.alu      = AluAdd;
    dec.sel_a    = SelRs1;

    if (instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        OpLui: begin
          dec.sel_a = SelZero;
          dec.sel_b = 1'b1;
          dec.imm   = imm_u;
        end
        OpAuipc: begin
          dec.sel_a = SelPc;
          dec.sel_b = 1'b1;
          dec.imm   = imm_u;
        end
        OpJal: begin
          dec.jump  = 1'b1;
          dec.sel_a = SelPc;
          dec.sel_b = 1'b1;
          dec.imm   = imm_j;
        end
        OpJalr: begin
          dec.jump  = 1'b1;
          dec.sel_b = 1'b1;
          dec.imm   = imm_i;
        end
        OpBranch: begin
          dec.branch = 1'b1;
          dec.rd     = '0;
          dec.alu    = AluSub;
          dec.imm    = imm_b;
        end
        OpLoad: begin
          dec.load  = 1'b1;
          dec.sel_b = 1'b1;
          dec.imm   = imm_i;
        end
        OpStore: begin
          dec.store = 1'b1;
          dec.rd    = '0;
          dec.sel_b = 1'b1;
          dec.imm   = imm_s;
        end
        OpImm: begin
          dec.sel_b = 1'b1;
          dec.imm   = imm_i;
          dec.alu   = alu_base(funct3, 1'b0);
          if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
            dec.illegal = 1'b1;
          end else if (funct3 == 3'b101) begin
            if (funct7 == 7'b0100000)      dec.alu     = AluSra;
            else if (funct7 != 7'b0000000) dec.illegal = 1'b1;
          end
        end
        OpOp: begin
          case (funct7)
            7'b0000000: dec.alu = alu_base(funct3, 1'b0);
            7'b0100000: begin
              if (funct3 == 3'b000 || funct3 == 3'b101) dec.alu = alu_base(funct3, 1'b1);
              else                                      dec.illegal = 1'b1;
            end
`ifdef DECODE_RV32M_EN
            7'b0000001: dec.alu = {2'b10, funct3};
`endif
            default:    dec.illegal = 1'b1;
          endcase
        end
        OpMisc: begin
          // FENCE / FENCE.I: no ordering to enforce in this pipeline, so retire as a NOP.
          dec.rd  = '0;
          dec.imm = imm_i;
        end
        OpSystem: begin
          dec.imm = imm_i;
          if (instr == 32'h0000_0073)                     dec.ecall   = 1'b1;
          else if (instr == 32'h0010_0073)                dec.ebreak  = 1'b1;
          else if (instr == 32'h3020_0073)                dec.mret    = 1'b1;
          else if (instr == 32'h1050_0073)                dec.rd      = '0;
          else if (funct3 != 3'b000 && funct3 != 3'b100)  dec.csr     = 1'b1;
          else                                            dec.illegal = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end

    if (dec.illegal) begin
      dec.load   = 1'b0;
      dec.store  = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
      dec.csr    = 1'b0;
      dec.ecall  = 1'b0;
      dec.ebreak = 1'b0;
      dec.mret   = 1'b0;
      dec.rd     = '0;
    end
  end

  // Stall holds everything; a bubble only needs valid and the class flags cleared.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (!bus.stall) begin
      if (bus.invalidate || !bus.valid_in) begin
        valid_d        = 1'b0;
        ctrl_d.load    = 1'b0;
        ctrl_d.store   = 1'b0;
        ctrl_d.branch  = 1'b0;
        ctrl_d.jump    = 1'b0;
        ctrl_d.csr     = 1'b0;
        ctrl_d.ecall   = 1'b0;
        ctrl_d.ebreak  = 1'b0;
        ctrl_d.mret    = 1'b0;
        ctrl_d.illegal = 1'b0;
      end else begin
        ctrl_d  = dec;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc_out           = ctrl_q.pc;
  assign bus.next_pc_out      = ctrl_q.next_pc;
  assign bus.rs1_data_out     = ctrl_q.rs1_data;
  assign bus.rs2_data_out     = ctrl_q.rs2_data;
  assign bus.imm_out          = ctrl_q.imm;
  assign bus.rd_address_out   = ctrl_q.rd;
  assign bus.rs1_address_out  = ctrl_q.rs1;
  assign bus.rs2_address_out  = ctrl_q.rs2;
  assign bus.alu_function_out = ctrl_q.alu;
  assign bus.alu_select_a_out = ctrl_q.sel_a;
  assign bus.alu_select_b_out = ctrl_q.sel_b;
  assign bus.funct3_out       = ctrl_q.funct3;
  assign bus.load_out         = ctrl_q.load;
  assign bus.store_out        = ctrl_q.store;
  assign bus.branch_out       = ctrl_q.branch;
  assign bus.jump_out         = ctrl_q.jump;
  assign bus.csr_out          = ctrl_q.csr;
  assign bus.ecall_out        = ctrl_q.ecall;
  assign bus.ebreak_out       = ctrl_q.ebreak;
  assign bus.mret_out         = ctrl_q.mret;
  assign bus.illegal_out      = ctrl_q.illegal;
  assign bus.valid_out        = valid_q;

endmodule

// File: tb/tb_decode.sv
// Randomized scoreboard bench for decode: driver pushes the expected post-edge state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_decode;

  typedef struct packed {
    logic        valid, load, store, branch, jump, csr, ecall, ebreak, mret, illegal;
    logic [4:0]  rd, rs1a, rs2a, alu;
    logic [1:0]  sa;
    logic        sb;
    logic [2:0]  f3;
    logic [31:0] imm, pc, npc, d1, d2;
  } exp_t;

`ifdef DECODE_RV32M_EN
  localparam bit RvM = 1'b1;
`else
  localparam bit RvM = 1'b0;
`endif

  localparam logic [4:0] AluTab [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  localparam logic [6:0] OpTab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h33};
  localparam logic [31:0] SysTab [5] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073,
                                         32'h1050_0073, 32'h0000_0000};
  localparam logic [6:0] F7Tab [3] = '{7'h00, 7'h20, 7'h01};

  logic clk = 1'b0;
  logic reset;
  decode_if bus ();

  decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t model;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode of a captured, live instruction (data/pc fields filled by the caller).
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] ib, ij;
    logic [31:0] ii;
    logic bad;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    ii = 32'($signed(w) >>> 20);
    ib = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    ij = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    e = '0;
    e.valid = 1'b1;
    e.rs1a = w[19:15];
    e.rs2a = w[24:20];
    e.rd = w[11:7];
    e.f3 = f3;
    bad = (w[1:0] != 2'b11);
    case (op)
      7'h37: begin e.sa = 2; e.sb = 1; e.imm = w & 32'hFFFF_F000; end
      7'h17: begin e.sa = 1; e.sb = 1; e.imm = w & 32'hFFFF_F000; end
      7'h6F: begin e.jump = 1; e.sa = 1; e.sb = 1; e.imm = ij; end
      7'h67: begin e.jump = 1; e.sb = 1; e.imm = ii; end
      7'h63: begin e.branch = 1; e.rd = 0; e.alu = 1; e.imm = ib; end
      7'h03: begin e.load = 1; e.sb = 1; e.imm = ii; end
      7'h23: begin e.store = 1; e.rd = 0; e.sb = 1; e.imm = (ii & ~32'h1F) | 32'(w[11:7]); end
      7'h13: begin
        e.sb = 1;
        e.imm = ii;
        e.alu = AluTab[f3];
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5 && f7 == 7'h20) e.alu = 7;
        else if (f3 == 5 && f7 != 0) bad = 1;
      end
      7'h33: begin
        if (f7 == 0) e.alu = AluTab[f3];
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) e.alu = AluTab[f3] + 5'd1;
        else if (f7 == 7'h01 && RvM) e.alu = 5'd16 + 5'(f3);
        else bad = 1;
      end
      7'h0F: begin e.rd = 0; e.imm = ii; end
      7'h73: begin
        e.imm = ii;
        if (w == 32'h0000_0073) e.ecall = 1;
        else if (w == 32'h0010_0073) e.ebreak = 1;
        else if (w == 32'h3020_0073) e.mret = 1;
        else if (w == 32'h1050_0073) e.rd = 0;
        else if (f3 != 0 && f3 != 4) e.csr = 1;
        else bad = 1;
      end
      default: bad = 1;
    endcase
    if (bad) begin
      {e.load, e.store, e.branch, e.jump, e.csr, e.ecall, e.ebreak, e.mret} = '0;
      e.illegal = 1;
      e.rd = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) w[6:0] = OpTab[k];
    else if (k == 13) w = SysTab[$urandom_range(0, 4)];
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 3)
      w[31:25] = F7Tab[$urandom_range(0, 2)];
    return w;
  endfunction

  // Drive one cycle (called just after a rising edge), then record the state expected after the
  // next rising edge.
  task automatic step(input logic st, input logic inv, input logic vin, input logic [31:0] w);
    logic [31:0] pc;
    pc = $urandom & ~32'd3;
    bus.stall = st;
    bus.invalidate = inv;
    bus.valid_in = vin;
    bus.instruction_in = w;
    bus.pc_in = pc;
    bus.next_pc_in = pc + 32'd4;
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    #1;
    chk("rs1_address", 32'(bus.rs1_address), 32'(w[19:15]));
    chk("rs2_address", 32'(bus.rs2_address), 32'(w[24:20]));
    if (reset) begin
      model = '0;
    end else if (!st) begin
      if (inv || !vin) begin
        model.valid = 0;
        {model.load, model.store, model.branch, model.jump, model.csr,
         model.ecall, model.ebreak, model.mret, model.illegal} = '0;
      end else begin
        model = ref_decode(w);
        model.pc = pc;
        model.npc = pc + 32'd4;
        model.d1 = bus.rs1_data;
        model.d2 = bus.rs2_data;
      end
    end
    @(posedge clk);
    sb.push_back(model);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid+flags"}, 32'({bus.valid_out, bus.load_out, bus.store_out, bus.branch_out,
        bus.jump_out, bus.csr_out, bus.ecall_out, bus.ebreak_out, bus.mret_out,
        bus.illegal_out}), 32'd0);
    chk({tag, " pc_out"}, bus.pc_out, 32'd0);
    chk({tag, " imm_out"}, bus.imm_out, 32'd0);
    chk({tag, " fields"}, 32'({bus.rd_address_out, bus.rs1_address_out, bus.rs2_address_out,
        bus.alu_function_out, bus.alu_select_a_out, bus.alu_select_b_out, bus.funct3_out}), 32'd0);
    chk({tag, " data"}, bus.rs1_data_out | bus.rs2_data_out | bus.next_pc_out, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid+flags", 32'({bus.valid_out, bus.load_out, bus.store_out, bus.branch_out,
            bus.jump_out, bus.csr_out, bus.ecall_out, bus.ebreak_out, bus.mret_out,
            bus.illegal_out}),
            32'({e.valid, e.load, e.store, e.branch, e.jump, e.csr, e.ecall, e.ebreak, e.mret,
            e.illegal}));
        if (e.valid) begin
          chk("rd_address_out", 32'(bus.rd_address_out), 32'(e.rd));
          chk("rs_address_out", 32'({bus.rs1_address_out, bus.rs2_address_out}),
              32'({e.rs1a, e.rs2a}));
          chk("funct3_out", 32'(bus.funct3_out), 32'(e.f3));
          chk("pc_out", bus.pc_out, e.pc);
          chk("next_pc_out", bus.next_pc_out, e.npc);
          chk("rs1_data_out", bus.rs1_data_out, e.d1);
          chk("rs2_data_out", bus.rs2_data_out, e.d2);
          if (!e.illegal) begin
            chk("alu_function_out", 32'(bus.alu_function_out), 32'(e.alu));
            chk("alu_select", 32'({bus.alu_select_a_out, bus.alu_select_b_out}),
                32'({e.sa, e.sb}));
            chk("imm_out", bus.imm_out, e.imm);
          end
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    bus.stall = 0;
    bus.invalidate = 0;
    bus.valid_in = 1;
    bus.instruction_in = 32'h0000_0073;
    bus.pc_in = 32'h100;
    bus.next_pc_in = 32'h104;
    bus.rs1_data = 32'hDEAD_BEEF;
    bus.rs2_data = 32'hCAFE_F00D;
    model = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    step(0, 0, 1, 32'hFFF1_0093);
    chk("addi imm", bus.imm_out, 32'hFFFF_FFFF);
    chk("addi rd/rs1", 32'({bus.rd_address_out, bus.rs1_address_out}), 32'({5'd1, 5'd2}));
    chk("addi alu/selb/valid", 32'({bus.alu_function_out, bus.alu_select_b_out, bus.valid_out}),
        32'({5'd0, 1'b1, 1'b1}));

    step(0, 0, 1, 32'h1234_52B7);
    chk("lui imm", bus.imm_out, 32'h1234_5000);
    chk("lui sela/rd", 32'({bus.alu_select_a_out, bus.rd_address_out}), 32'({2'd2, 5'd5}));

    step(0, 0, 1, 32'h0220_81B3);
`ifdef DECODE_RV32M_EN
    chk("mul alu", 32'(bus.alu_function_out), 32'd16);
`else
    chk("mul illegal/rd", 32'({bus.illegal_out, bus.rd_address_out}), 32'({1'b1, 5'd0}));
`endif

    step(0, 0, 1, 32'h0000_0073);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, gen_instr());
      chk("stall ecall/valid", 32'({bus.ecall_out, bus.valid_out}), 32'b11);
    end
    step(0, 1, 1, gen_instr());
    chk("invalidate valid", 32'(bus.valid_out), 32'd0);

    step(0, 0, 1, 32'h0000_0000);
    chk("zero word illegal", 32'({bus.illegal_out, bus.valid_out}), 32'b11);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    step(1, 0, 1, gen_instr());
    reset = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 85, gen_instr());
    end

    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
No parameters.
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 pc_in / next_pc_in  input  32 each  fetched instruction address and its address + 4.
REQ-004 instruction_in  input  32  raw RV32 instruction word.
REQ-005 valid_in  input  1  instruction_in holds a real instruction.
REQ-006 stall / invalidate  input  1 each  from hazard unit.
REQ-007 rs1_address / rs2_address  output  5 each  combinational register-file read addresses, taken as instruction_in[19:15] and [24:20].
REQ-008 rs1_data / rs2_data  input  32 each  register-file read data, valid in the same cycle.
REQ-009 pc_out / next_pc_out  output  32 each  registered copies of pc_in and next_pc_in.
REQ-010 rs1_data_out / rs2_data_out / imm_out  output  32 each  operands and sign-extended immediate.
REQ-011 rd_address_out / rs1_address_out / rs2_address_out  output  5 each  register indices; rd_address_out is 0 when the instruction has no rd write.
REQ-012 alu_function_out  output  5  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL..REMU=16..23.
REQ-013 alu_select_a_out  output  2  0=rs1, 1=pc, 2=zero.
REQ-014 alu_select_b_out  output  1  0=rs2, 1=imm.
REQ-015 funct3_out  output  3  for load/store width, branch condition and CSR op.
REQ-016 load_out, store_out, branch_out, jump_out, csr_out, ecall_out, ebreak_out, mret_out, illegal_out  output  1 each  class flags.
REQ-017 valid_out  output  1  outputs describe a live instruction.

Function
REQ-018 All outputs except rs*_address are registered, with exactly one cycle of latency from instruction_in to outputs.
REQ-019 Clock edge with stall=1: every output register holds, regardless of invalidate; stall wins over invalidate.
REQ-020 Clock edge with stall=0 and invalidate=1: valid_out <= 0; other registers are don't-care and must not assert any class flag.
REQ-021 Clock edge with stall=0, invalidate=0, valid_in=0: valid_out <= 0 and all class flags <= 0.
REQ-022 Clock edge with stall=0, invalidate=0, valid_in=1: capture the decode and set valid_out <= 1.
REQ-023 Immediates are sign-extended from bit 31 in I/S/B/U/J formats; B and J formats have bit 0 = 0; U format has low 12 bits = 0.
REQ-024 LUI: select_a=zero, select_b=imm, ADD. AUIPC: select_a=pc, ADD. JAL/JALR: jump_out=1, rd=link. Branches: branch_out=1, rd=0, SUB.
REQ-025 OP-IMM/OP: ALU function comes from funct3 and funct7[5]. SUB and SRA are legal only with funct7=0100000; all other funct7 values except the RVM case are illegal.
REQ-026 SYSTEM: ECALL (0x00000073), EBREAK (0x00100073) and MRET (0x30200073) each set their flag. CSRRW/S/C and their immediate forms set csr_out. WFI is a NOP. Other SYSTEM encodings are illegal.
REQ-027 FENCE and FENCE.I decode as NOP with valid_out=1.
REQ-028 Unknown opcode, or bits[1:0] != 11: illegal_out=1, valid_out=1, and all other class flags plus rd_address_out are forced to 0.

Reset
REQ-029 While reset=1, all registered outputs are immediately 0, independent of clk; this includes valid_out=0 and all flags=0.
REQ-030 The first capture happens on the first rising edge after reset deasserts; reset during a stall discards the held instruction.

Configuration
REQ-031 Macro DECODE_RV32M_EN defined: OP with funct7=0000001 decodes to MUL..REMU (alu_function 16+funct3). Macro undefined: the same encoding sets illegal_out=1 and codes 16..23 are never produced.

Verification
REQ-032 0xFFF10093 (addi x1,x2,-1), valid_in=1 -> next cycle: rd=1, rs1=2, imm=0xFFFFFFFF, ADD, select_b=1, valid_out=1.
REQ-033 0x123452B7 (lui x5,0x12345) -> imm_out=0x12345000, select_a=2, rd=5.
REQ-034 0x022081B3 (mul x3,x1,x2) -> alu_function=16 with DECODE_RV32M_EN; illegal_out=1 and rd=0 without it.
REQ-035 Capture 0x00000073, then hold stall=1 with invalidate=1 for 3 cycles -> ecall_out=1 and valid_out=1 throughout. Release stall with invalidate=1 -> valid_out=0.
REQ-036 Apply 0x00000000 -> illegal_out=1. Then assert reset mid-cycle -> all outputs 0 before the next edge.
